// File: rtl/sig_trace_buffer_if.sv
// Sample stream and display read port of the signal trace buffer.
// The master side feeds samples and issues display reads; the slave side is the buffer.
interface sig_trace_buffer_if;
  logic        s_valid;
  logic        s_chan;
  logic [11:0] s_data;
  logic        s_ready;
  logic [11:0] sig_addr;
  logic [31:0] sig_data;

  modport master (output s_valid, s_chan, s_data, sig_addr,
                  input  s_ready, sig_data);
  modport slave  (input  s_valid, s_chan, s_data, sig_addr,
                  output s_ready, sig_data);
endinterface

// File: rtl/sig_trace_buffer.sv
// Two-channel decimating trace buffer for a scrolling display: averages DECIM samples per
// point, stores DEPTH points per channel in a ring, and serves them oldest-first per frame.
module sig_trace_buffer #(
  parameter int unsigned DEPTH  = 320,
  parameter int unsigned DECIM  = 4,
  parameter logic [11:0] BASE_A = 12'h559,
  parameter logic [11:0] BASE_B = 12'h6AD
) (
  input  logic              clock,
  input  logic              reset,
  sig_trace_buffer_if.slave bus,
  input  logic              frame_end,
  input  logic              freeze,
  output logic [8:0]        wr_ptr_a,
  output logic [8:0]        wr_ptr_b,
  output logic              busy
);
  localparam int unsigned SHIFT    = $clog2(DECIM);
  localparam logic [8:0]  LAST_PTR = 9'(DEPTH - 1);
  localparam logic [9:0]  LAST_CLR = 10'(2 * DEPTH - 1);
  localparam logic [9:0]  DEPTH_W  = 10'(DEPTH);
  localparam logic [4:0]  LAST_CNT = 5'(DECIM - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t     state, state_nxt;
  logic [9:0] clr_idx, clr_idx_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    busy        = 1'b0;
    bus.s_ready = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx == LAST_CLR) begin
          state_nxt   = RUN;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + 10'd1;
        end
      end
      RUN:     bus.s_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  // Decimation: frozen samples are handshaken but never reach the accumulators.
  logic        accept;
  logic [15:0] acc [2];
  logic [4:0]  cnt [2];
  logic [15:0] sum;
  logic        last;
  logic        pend_valid;
  logic        pend_chan;
  logic [11:0] pend_point;

  assign accept = bus.s_valid & bus.s_ready & ~freeze;
  assign sum    = acc[bus.s_chan] + 16'(bus.s_data);
  assign last   = (cnt[bus.s_chan] == LAST_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
      pend_valid <= 1'b0;
      pend_chan  <= 1'b0;
      pend_point <= '0;
    end else begin
      pend_valid <= accept & last;
      if (accept) begin
        if (last) begin
          acc[bus.s_chan] <= '0;
          cnt[bus.s_chan] <= '0;
          pend_chan       <= bus.s_chan;
          pend_point      <= 12'(sum >> SHIFT);
        end else begin
          acc[bus.s_chan] <= sum;
          cnt[bus.s_chan] <= cnt[bus.s_chan] + 5'd1;
        end
      end
    end
  end

  function automatic logic [8:0] ptr_inc(input logic [8:0] p);
    return (p == LAST_PTR) ? 9'd0 : p + 9'd1;
  endfunction

  // Snapshots sample the pointers before this cycle's increment lands.
  logic [8:0] snap_a, snap_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_a <= '0;
      wr_ptr_b <= '0;
      snap_a   <= '0;
      snap_b   <= '0;
    end else begin
      if (pend_valid) begin
        if (pend_chan) wr_ptr_b <= ptr_inc(wr_ptr_b);
        else           wr_ptr_a <= ptr_inc(wr_ptr_a);
      end
      if (frame_end && !freeze) begin
        snap_a <= wr_ptr_a;
        snap_b <= wr_ptr_b;
      end
    end
  end

  // Channel A occupies entries [0, DEPTH), channel B entries [DEPTH, 2*DEPTH).
  logic [11:0] mem [2*DEPTH];
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [11:0] mem_wr_data;

  always_comb begin
    mem_wr_en   = pend_valid;
    mem_wr_addr = pend_chan ? DEPTH_W + {1'b0, wr_ptr_b} : {1'b0, wr_ptr_a};
    mem_wr_data = pend_point;
    if (state == CLEAR) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = clr_idx;
      mem_wr_data = '0;
    end
  end

  // NOTE: the storage array has no reset; the CLEAR sweep zeroes it after every reset instead.
  always_ff @(posedge clock) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  logic [12:0] off_a, off_b;
  logic        in_a, in_b;
  logic [9:0]  raw_a, raw_b, idx_a, idx_b;
  logic        rd_hit;
  logic [9:0]  rd_addr;

  assign off_a = {1'b0, bus.sig_addr} - {1'b0, BASE_A};
  assign off_b = {1'b0, bus.sig_addr} - {1'b0, BASE_B};
  assign in_a  = (bus.sig_addr >= BASE_A) && (off_a < 13'(DEPTH));
  assign in_b  = (bus.sig_addr >= BASE_B) && (off_b < 13'(DEPTH));
  assign raw_a = {1'b0, snap_a} + {1'b0, off_a[8:0]};
  assign raw_b = {1'b0, snap_b} + {1'b0, off_b[8:0]};
  assign idx_a = (raw_a >= DEPTH_W) ? raw_a - DEPTH_W : raw_a;
  assign idx_b = (raw_b >= DEPTH_W) ? raw_b - DEPTH_W : raw_b;

  always_comb begin
    rd_hit  = 1'b0;
    rd_addr = '0;
    if (state == RUN) begin
      if (in_a) begin
        rd_hit  = 1'b1;
        rd_addr = idx_a;
      end else if (in_b) begin
        rd_hit  = 1'b1;
        rd_addr = DEPTH_W + idx_b;
      end
    end
  end

  // Registered read alongside the write port gives read-first behaviour on a collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       bus.sig_data <= '0;
    else if (rd_hit) bus.sig_data <= {20'b0, mem[rd_addr]};
    else             bus.sig_data <= '0;
  end
endmodule

// File: tb/tb_sig_trace_buffer.sv
// Directed self-checking bench for sig_trace_buffer with default parameters.
module tb_sig_trace_buffer;
  localparam logic [11:0] BASE_A = 12'h559;
  localparam logic [11:0] BASE_B = 12'h6AD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0;
  logic       freeze = 1'b0;
  logic [8:0] wr_ptr_a, wr_ptr_b;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  sig_trace_buffer_if bus ();

  sig_trace_buffer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .frame_end (frame_end),
    .freeze    (freeze),
    .wr_ptr_a  (wr_ptr_a),
    .wr_ptr_b  (wr_ptr_b),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [11:0] exp);
    bus.sig_addr = addr;
    step();
    check(tag, bus.sig_data, {20'b0, exp});
  endtask

  task automatic sample(input logic ch, input logic [11:0] d);
    bus.s_valid = 1'b1;
    bus.s_chan  = ch;
    bus.s_data  = d;
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check(tag, n, 640);
  endtask

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_chan   = 1'b0;
    bus.s_data   = '0;
    bus.sig_addr = '0;
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_ready", bus.s_ready, 0);
    check("rst_data", bus.sig_data, 0);
    check("rst_ptr_a", wr_ptr_a, 0);
    check("rst_ptr_b", wr_ptr_b, 0);

    reset = 1'b0;
    count_busy("clear_len");
    check("run_ready", bus.s_ready, 1);
    rd("clr_a_first", BASE_A, 0);
    rd("clr_a_last", BASE_A + 12'd319, 0);
    rd("clr_b_first", BASE_B, 0);

    // Four A samples average to 250, visible as newest after the frame boundary.
    sample(0, 12'd100);
    sample(0, 12'd200);
    sample(0, 12'd300);
    sample(0, 12'd400);
    step();
    pulse_frame();
    check("avg_ptr_a", wr_ptr_a, 1);
    rd("avg_newest", BASE_A + 12'd319, 12'd250);
    rd("avg_oldest", BASE_A, 0);

    // Interleaved channels: B averages 1..4 to 2 (truncated), A gets 8.
    sample(1, 12'd1);
    sample(0, 12'd8);
    sample(1, 12'd2);
    sample(0, 12'd8);
    sample(1, 12'd3);
    sample(0, 12'd8);
    sample(1, 12'd4);
    sample(0, 12'd8);
    step();
    pulse_frame();
    check("mix_ptr_a", wr_ptr_a, 2);
    check("mix_ptr_b", wr_ptr_b, 1);
    rd("mix_a_newest", BASE_A + 12'd319, 12'd8);
    rd("mix_b_newest", BASE_B + 12'd319, 12'd2);
    rd("mix_b_oldest", BASE_B, 0);

    // Points 2..320 carry their own index; 321 points total wrap the A ring once.
    for (int p = 2; p <= 320; p++)
      for (int j = 0; j < 4; j++) sample(0, 12'(p));
    step();
    pulse_frame();
    check("wrap_ptr_a", wr_ptr_a, 1);
    rd("wrap_oldest", BASE_A, 12'd8);
    rd("wrap_newest", BASE_A + 12'd319, 12'd320);
    rd("wrap_mid", BASE_A + 12'd4, 12'd5);

    rd("out_below_a", 12'h558, 0);
    rd("out_above_a", 12'h699, 0);
    rd("out_below_b", 12'h6AC, 0);
    rd("out_above_b", 12'h7ED, 0);

    freeze = 1'b1;
    check("frz_ready", bus.s_ready, 1);
    for (int j = 0; j < 8; j++) sample(0, 12'd4095);
    step();
    pulse_frame();
    check("frz_ptr_a", wr_ptr_a, 1);
    rd("frz_oldest", BASE_A, 12'd8);
    rd("frz_newest", BASE_A + 12'd319, 12'd320);
    freeze = 1'b0;

    // Fourth sample coincides with frame_end; the write to index 1 collides with a read of it.
    sample(0, 12'd40);
    sample(0, 12'd40);
    sample(0, 12'd40);
    bus.s_valid  = 1'b1;
    bus.s_chan   = 1'b0;
    bus.s_data   = 12'd40;
    bus.sig_addr = BASE_A;
    frame_end    = 1'b1;
    step();
    bus.s_valid = 1'b0;
    frame_end   = 1'b0;
    step();
    check("read_first", bus.sig_data, 8);
    check("coin_ptr_a", wr_ptr_a, 2);
    rd("coin_new_idx", BASE_A, 12'd40);
    rd("coin_newest", BASE_A + 12'd319, 12'd320);
    pulse_frame();
    rd("coin_visible", BASE_A + 12'd319, 12'd40);
    rd("coin_oldest", BASE_A, 12'd2);

    reset = 1'b1;
    #1;
    check("rerst_data", bus.sig_data, 0);
    check("rerst_ptr_a", wr_ptr_a, 0);
    check("rerst_ptr_b", wr_ptr_b, 0);
    check("rerst_busy", busy, 1);
    step();
    reset = 1'b0;
    bus.sig_addr = BASE_B;
    step();
    check("clear_read", bus.sig_data, 0);
    for (int k = 1; k < 300; k++) step();
    check("mid_clear_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("reclear_len");
    rd("reclear_000", 12'h000, 0);
    rd("reclear_fff", 12'hFFF, 0);
    rd("reclear_b_first", BASE_B, 0);
    rd("reclear_a_last", BASE_A + 12'd319, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sig_trace_buffer.md
SIG_TRACE_BUFFER -- requirements
Module: sig_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 320, points stored per channel (one per plotted column).
REQ-002 Parameter DECIM, default 4, input samples averaged per stored point; a power of two, 1..16.
REQ-003 Parameter BASE_A, default 12'h559, first display address of channel A (ECG).
REQ-004 Parameter BASE_B, default 12'h6AD, first display address of channel B (EMG).
REQ-005 clock  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_valid  in  1  input sample strobe.
REQ-008 s_chan  in  1  sample channel, 0=A, 1=B.
REQ-009 s_data  in  12  unsigned sample.
REQ-010 s_ready  out  1  sample accepted when s_valid and s_ready are both high.
REQ-011 frame_end  in  1  single-cycle pulse, display frame boundary, synchronous to clock.
REQ-012 freeze  in  1  level; holds the displayed trace.
REQ-013 sig_addr  in  12  display read address.
REQ-014 sig_data  out  32  display read data.
REQ-015 wr_ptr_a, wr_ptr_b  out  9 each  next write index per channel.
REQ-016 busy  out  1  high while clearing.

Function
REQ-017 The state machine SHALL have two states, CLEAR and RUN; reset enters CLEAR with clear index 0.
REQ-018 CLEAR SHALL write 0 to one entry per cycle, covering 2*DEPTH entries (A then B), then enter RUN on the next cycle; busy=1 and s_ready=0 throughout CLEAR.
REQ-019 RUN SHALL hold s_ready=1 and busy=0; CLEAR is re-entered only by reset.
REQ-020 Per channel, the block SHALL keep a sample counter and a 16-bit accumulator; each accepted sample adds s_data to that channel's accumulator and increments its counter.
REQ-021 On the DECIMth accepted sample of a channel, the stored point SHALL be (accumulator + s_data) >> log2(DECIM), truncated.
REQ-022 That point SHALL be written at wr_ptr of the channel in the cycle after acceptance; the accumulator and counter clear in the acceptance cycle.
REQ-023 wr_ptr SHALL increment after each write, wrapping from DEPTH-1 to 0.
REQ-024 While freeze=1, samples are accepted (s_ready=1) and discarded; accumulators, counters, pointers and memory are unchanged.
REQ-025 On frame_end with freeze=0, snap_a and snap_b SHALL latch wr_ptr_a and wr_ptr_b; the latched value is the pre-increment pointer if a write occurs in the same cycle.
REQ-026 On frame_end with freeze=1, the snapshots SHALL be held.
REQ-027 For sig_addr in [BASE_A, BASE_A+DEPTH), with i = sig_addr-BASE_A, the block SHALL read channel A entry (snap_a+i) mod DEPTH; channel B likewise with BASE_B and snap_b.
REQ-028 The mod SHALL be computed as a single conditional subtract of DEPTH.
REQ-029 The result SHALL appear on sig_data, registered, one clock after sig_addr is presented; i=0 gives the oldest point and i=DEPTH-1 the newest.
REQ-030 sig_data[11:0] SHALL carry the point and sig_data[31:12] SHALL be 0.
REQ-031 Addresses outside both windows SHALL return 0; addresses during CLEAR SHALL return 0.
REQ-032 A read of the entry being written in the same cycle SHALL return the old contents (read-first).
REQ-033 Pointer width SHALL be 9 bits; DEPTH > 511 is unsupported.

Reset
REQ-034 Reset asserted SHALL immediately force: busy=1, s_ready=0, sig_data=0, wr_ptr_a=wr_ptr_b=0, snapshots=0, accumulators=0, counters=0.
REQ-035 Reset asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from index 0; partial accumulations are lost.

Verification
REQ-036 Reset, then count cycles -> busy=1 for exactly 640 cycles; all reads return 0 afterward.
REQ-037 Channel A, four samples 100,200,300,400, freeze=0, then frame_end -> read 12'h559+319 returns 250 one cycle later; wr_ptr_a=1.
REQ-038 Channel A, 321 points written, frame_end -> wr_ptr_a=1; read 12'h559 returns the value of point 1; read 12'h559+319 returns point 320, stored at index 0.
REQ-039 Run with freeze=1, eight A samples of 4095, then frame_end -> wr_ptr_a and all reads unchanged.
REQ-040 Fourth A sample accepted in the same cycle as frame_end -> snap_a holds the old pointer; the new point stays invisible until the next frame_end.
REQ-041 Assert reset during CLEAR at index 300 -> busy stays high for 640 cycles after release; reads of 12'h000 and 12'hFFF return 0.
